multicycle_controller: RTL

// - Control FSM for the multicycle ARM-subset datapath: instruction memory/IR, PC, PC+4/PC+8 adders, RA1/RA2 muxes, register file, ALU, data memory.
// - Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath select and write strobe.
// - Owns the NZCV flags register and condition-code evaluation.

---
 rtl/multicycle_controller_pkg.sv | 93 +++++++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller_cond_unit.sv | 37 +++
 rtl/multicycle_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared encodings, FSM state type and condition evaluation for the multicycle controller.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package multicycle_controller_pkg;

    typedef logic [3:0] nzcv_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instruction class in IR[27:26]
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operand selects
    localparam logic       SRCA_RD1  = 1'b0;
    localparam logic       SRCA_PC   = 1'b1;
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Data-processing cmd field IR[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field IR[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Evaluate an ARM condition against NZCV; the 1111 encoding never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input nzcv_t f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose: bundles instruction fields/ALU flags in and all datapath controls out.
// Latency: wires only.
// Backpressure: none; the controller never stalls.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [3:0] instr_cond;
    logic [1:0] instr_op;
    logic [5:0] instr_funct;
    logic [3:0] instr_rd;
    nzcv_t      alu_flags;

    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] state;

    // Controller side
    modport master (
        input  instr_cond, instr_op, instr_funct, instr_rd, alu_flags,
        output pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
    );

    // Datapath side
    modport slave (
        output instr_cond, instr_op, instr_funct, instr_rd, alu_flags,
        input  pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
    );

endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// Purpose: NZCV flags register, flag-write masking and per-instruction condition latch.
// Latency: flags visible the cycle after execute; cond_ex_q valid the cycle after decode.
// Backpressure: none.
module multicycle_controller_cond_unit
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  nzcv_t      alu_flags,
    input  logic [1:0] flag_req,      // [1]=NZ write, [0]=CV write, before condition gating
    input  logic       ex_stage,
    input  logic       decode_stage,
    output logic       cond_ex_q
);

    nzcv_t      flags_q;
    logic [1:0] flag_we;
    logic       cond_ex;

    assign cond_ex = cond_eval(cond, flags_q);
    // A failed condition must not disturb the flags either.
    assign flag_we = flag_req & {2{ex_stage & cond_ex_q}};

    // Flags and condition latch; cond_ex_q holds for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            if (flag_we[1]) flags_q[3:2] <= alu_flags[3:2];
            if (flag_we[0]) flags_q[1:0] <= alu_flags[1:0];
            if (decode_stage) cond_ex_q <= cond_ex;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle ARM-subset control FSM driving all datapath selects and write strobes.
// Latency: DP 4, LDR 5, STR 4, B 3, undefined 2 cycles per instruction.
// Backpressure: none; one state per cycle, strobes forced low while reset is asserted.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_controller_if.master ctrl
);

    state_t     state_q;
    state_t     state_d;

    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_w;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;

    logic [1:0] alu_ctrl_dp;
    logic       nz_req;
    logic       cv_req;
    logic       no_write;
    logic       ex_stage;
    logic       cond_ex_q;
    logic       rd_is_pc;

    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = ctrl.instr_funct[4:1];
    assign s_bit = ctrl.instr_funct[0];

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state and per-state main-decoder outputs.
    always_comb begin
        state_d    = S_FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        ir_w       = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_w       = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // PC+4 again so an R15 read sees PC+8.
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                case (ctrl.instr_op)
                    OP_DP:    state_d = ctrl.instr_funct[5] ? S_EXEI : S_EXER;
                    OP_MEM:   state_d = S_MEMADR;
                    OP_BR:    state_d = S_BRANCH;
                    OP_UNDEF: state_d = S_FETCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = ctrl.instr_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXER: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXEI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decoder: operation, flag-write requests and register-write suppression.
    always_comb begin
        alu_ctrl_dp = ALU_ADD;
        nz_req      = 1'b0;
        cv_req      = 1'b0;
        no_write    = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_ctrl_dp = ALU_ADD; nz_req = s_bit; cv_req = s_bit; end
            CMD_SUB: begin alu_ctrl_dp = ALU_SUB; nz_req = s_bit; cv_req = s_bit; end
            CMD_AND: begin alu_ctrl_dp = ALU_AND; nz_req = s_bit; end
            CMD_ORR: begin alu_ctrl_dp = ALU_ORR; nz_req = s_bit; end
            CMD_CMP: begin alu_ctrl_dp = ALU_SUB; nz_req = s_bit; cv_req = s_bit; no_write = 1'b1; end
            default: begin alu_ctrl_dp = ALU_ADD; no_write = 1'b1; end
        endcase
        // Memory instructions reuse these bits as P/U/B/W; never suppress their writeback.
        if (ctrl.instr_op != OP_DP) no_write = 1'b0;
    end

    assign ex_stage = (state_q == S_EXER) || (state_q == S_EXEI);
    assign rd_is_pc = (ctrl.instr_rd == 4'hF);

    multicycle_controller_cond_unit u_cond (
        .clk          (clk),
        .reset_n      (reset_n),
        .cond         (ctrl.instr_cond),
        .alu_flags    (ctrl.alu_flags),
        .flag_req     ({nz_req, cv_req}),
        .ex_stage     (ex_stage),
        .decode_stage (state_q == S_DECODE),
        .cond_ex_q    (cond_ex_q)
    );

    // Strobes are gated by the latched condition and forced off during reset.
    assign ctrl.ir_write    = ir_w & reset_n;
    assign ctrl.mem_write   = mem_w & cond_ex_q & reset_n;
    assign ctrl.reg_write   = reg_w & cond_ex_q & ~no_write & reset_n;
    assign ctrl.pc_write    = (next_pc | (cond_ex_q & (branch | (reg_w & rd_is_pc & ~no_write))))
                              & reset_n;

    assign ctrl.adr_src     = adr_src;
    assign ctrl.result_src  = result_src;
    assign ctrl.alu_src_a   = alu_src_a;
    assign ctrl.alu_src_b   = alu_src_b;
    assign ctrl.alu_control = alu_op ? alu_ctrl_dp : ALU_ADD;
    assign ctrl.imm_src     = ctrl.instr_op;
    assign ctrl.reg_src     = {(ctrl.instr_op == OP_MEM) & ~ctrl.instr_funct[0],
                               (ctrl.instr_op == OP_BR)};
    assign ctrl.state       = state_q;

endmodule
